// File: rtl/fpu_arbiter.sv
// fpu_arbiter: round-robin arbiter granting two requesters access to one shared half-precision FPU.
// Define FPU_ARB_OPCHECK_EN to answer opcodes other than FADD/FMUL directly with an error response.
`timescale 1ns/1ps
module fpu_arbiter #(
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic [3:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  input  logic [3:0]  req1_op,
  output logic [15:0] fpu_a,
  output logic [15:0] fpu_b,
  output logic [3:0]  fpu_aluctrl,
  input  logic [15:0] fpu_result,
  input  logic        fpu_zero,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  localparam logic [3:0] LAT4 = 4'(LATENCY);

  state_t      state, state_nxt;
  logic        ptr;
  logic [3:0]  cnt;
  logic        grant_id;
  logic        grant_any;
  logic        op_bad;
  logic [15:0] sel_a, sel_b;
  logic [3:0]  sel_op;

  // Pointer only breaks ties; a lone valid requester always wins.
  always_comb begin
    grant_id   = (req0_valid && req1_valid) ? ptr : req1_valid;
    grant_any  = (state == IDLE) && (req0_valid || req1_valid);
    req0_ready = grant_any && !grant_id;
    req1_ready = grant_any && grant_id;
    sel_a      = grant_id ? req1_a  : req0_a;
    sel_b      = grant_id ? req1_b  : req0_b;
    sel_op     = grant_id ? req1_op : req0_op;
  end

`ifdef FPU_ARB_OPCHECK_EN
  localparam logic [3:0] FPU_FADD = 4'h0;
  localparam logic [3:0] FPU_FMUL = 4'h1;

  logic err_q;

  assign op_bad = (sel_op != FPU_FADD) && (sel_op != FPU_FMUL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            err_q <= 1'b0;
    else if (grant_any) err_q <= op_bad;
  end

  assign rsp_err = err_q;
`else
  assign op_bad  = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (grant_any) state_nxt = op_bad ? DONE : EXEC;
      EXEC:    if (cnt == 4'd1) state_nxt = DONE;
      DONE:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign rsp_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr         <= 1'b0;
      cnt         <= '0;
      fpu_a       <= '0;
      fpu_b       <= '0;
      fpu_aluctrl <= '0;
      rsp_id      <= 1'b0;
      rsp_result  <= '0;
      rsp_zero    <= 1'b0;
    end else if (grant_any) begin
      ptr         <= ~grant_id;
      cnt         <= op_bad ? 4'd0 : LAT4;
      fpu_a       <= sel_a;
      fpu_b       <= sel_b;
      fpu_aluctrl <= sel_op;
      rsp_id      <= grant_id;
      if (op_bad) begin
        rsp_result <= '0;
        rsp_zero   <= 1'b1;
      end
    end else if (state == EXEC) begin
      cnt <= cnt - 4'd1;
      // The FPU has settled by the final EXEC edge; capture its output for DONE.
      if (cnt == 4'd1) begin
        rsp_result <= fpu_result;
        rsp_zero   <= fpu_zero;
      end
    end
  end

endmodule

// File: tb/tb_fpu_arbiter.sv
// tb_fpu_arbiter: table-driven and scenario checks of fpu_arbiter against a behavioural FPU stub,
// with a response scoreboard that also checks response latency and output stability.
`timescale 1ns/1ps
module tb_fpu_arbiter;

  localparam int unsigned LAT = 2;
  localparam logic [3:0] OP_FADD = 4'h0;
  localparam logic [3:0] OP_FMUL = 4'h1;
  localparam logic [3:0] OP_BAD  = 4'hF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [3:0]  req0_op = '0, req1_op = '0;
  logic [15:0] fpu_a, fpu_b, fpu_result;
  logic [3:0]  fpu_aluctrl;
  logic        fpu_zero;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_id, rsp_zero, rsp_err, busy;
  logic [15:0] rsp_result;

  typedef struct {
    logic        id;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  op;
    logic [15:0] res;
    logic        zero;
    logic        err;
  } vec_t;

  typedef struct {
    logic        id;
    logic [15:0] res;
    logic        zero;
    logic        err;
    int          due;
  } rsp_t;

  rsp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  fpu_arbiter #(.LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_aluctrl(fpu_aluctrl),
    .fpu_result(fpu_result), .fpu_zero(fpu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .busy(busy)
  );

  // Known half-precision results for the exercised operands; anything else gets a cheap hash.
  function automatic logic [15:0] fpu_model(input logic [15:0] a, input logic [15:0] b,
                                            input logic [3:0] op);
    if (op == OP_FADD && a == 16'h3C00 && b == 16'h4000) return 16'h4200;
    if (op == OP_FADD && a == 16'h3C00 && b == 16'hBC00) return 16'h0000;
    if (op == OP_FADD && a == 16'h3E00 && b == 16'h3E00) return 16'h4200;
    if (op == OP_FMUL && a == 16'h4000 && b == 16'h4200) return 16'h4600;
    return a ^ b ^ {12'h000, op};
  endfunction

  assign fpu_result = fpu_model(fpu_a, fpu_b, fpu_aluctrl);
  assign fpu_zero   = (fpu_result[14:0] == 15'd0);

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  function automatic vec_t mk(input logic id, input logic [15:0] a, input logic [15:0] b,
                              input logic [3:0] op, input logic [15:0] res,
                              input logic zero, input logic err);
    vec_t v;
    v.id = id; v.a = a; v.b = b; v.op = op; v.res = res; v.zero = zero; v.err = err;
    return v;
  endfunction

  // Scoreboard consumer plus per-cycle latency, stability and ready-gating checks.
  logic        pv = 1'b0, phs = 1'b0, p_id = 1'b0, p_zero = 1'b0, p_err = 1'b0;
  logic [15:0] p_res = '0;
  logic [35:0] pf = '0;
  always @(negedge clk) begin
    rsp_t x;
    if (rst) begin
      pv = 1'b0; phs = 1'b0; pf = '0;
    end else begin
      if (rsp_valid) begin
        if (!pv) begin
          if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL rsp_unexpected actual=rsp_valid id=%0d result=%h required=no response",
                     rsp_id, rsp_result);
          end else chk("rsp_latency", cyc, sb[0].due);
        end else begin
          chk("rsp_hold", {rsp_id, rsp_result, rsp_zero, rsp_err}, {p_id, p_res, p_zero, p_err});
        end
        if (rsp_ready && sb.size() != 0) begin
          x = sb.pop_front();
          chk("rsp_id", rsp_id, x.id);
          chk("rsp_result", rsp_result, x.res);
          chk("rsp_zero", rsp_zero, x.zero);
          chk("rsp_err", rsp_err, x.err);
        end
      end
      if (busy) chk("ready_in_busy", {req0_ready, req1_ready}, 2'b00);
      if (req0_valid && req1_valid) chk("ready_excl", req0_ready && req1_ready, 1'b0);
      if (!phs) chk("fpu_hold", {fpu_a, fpu_b, fpu_aluctrl}, pf);
      pv = rsp_valid && !rsp_ready;
      p_id = rsp_id; p_res = rsp_result; p_zero = rsp_zero; p_err = rsp_err;
      pf = {fpu_a, fpu_b, fpu_aluctrl};
      phs = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    end
  end

  task automatic drive_req(input vec_t v, input logic valid);
    if (v.id) begin
      req1_a = v.a; req1_b = v.b; req1_op = v.op; req1_valid = valid;
    end else begin
      req0_a = v.a; req0_b = v.b; req0_op = v.op; req0_valid = valid;
    end
  endtask

  task automatic expect_rsp(input vec_t v);
    rsp_t x;
    x.id = v.id; x.res = v.res; x.zero = v.zero; x.err = v.err;
    x.due = cyc + (v.err ? 1 : int'(LAT) + 1);
    sb.push_back(x);
  endtask

  task automatic wait_grant(input logic id, input int max, output bit got, output int n);
    got = 1'b0; n = 0;
    while (!got && n < max) begin
      @(negedge clk);
      if ((id ? req1_ready : req0_ready) === 1'b1) got = 1'b1;
      else n++;
    end
    chk("grant_wait", got, 1'b1);
  endtask

  // Issue one request from an idle arbiter; returns at the negedge of the first cycle after the grant.
  task automatic issue(input vec_t v);
    bit got;
    int n;
    @(posedge clk); #1;
    drive_req(v, 1'b1);
    wait_grant(v.id, 20, got, n);
    if (got) begin
      expect_rsp(v);
      chk("grant_at_T", n, 0);
    end
    @(posedge clk); #1;
    drive_req(v, 1'b0);
    @(negedge clk);
    if (got) begin
      chk("fpu_a", fpu_a, v.a);
      chk("fpu_b", fpu_b, v.b);
      chk("fpu_aluctrl", fpu_aluctrl, v.op);
    end
  endtask

  task automatic drain(input int max);
    int n = 0;
    while (sb.size() != 0 && n < max) begin
      @(negedge clk);
      n++;
    end
    #1 chk("drain", sb.size(), 0);
  endtask

  task automatic both(input vec_t v0, input vec_t v1, input logic first, input string tag);
    vec_t f, s;
    bit got;
    int n;
    f = first ? v1 : v0;
    s = first ? v0 : v1;
    @(posedge clk); #1;
    drive_req(v0, 1'b1);
    drive_req(v1, 1'b1);
    @(negedge clk);
    chk({tag, "_r0"}, req0_ready, !first);
    chk({tag, "_r1"}, req1_ready, first);
    expect_rsp(f);
    @(posedge clk); #1;
    drive_req(f, 1'b0);
    wait_grant(s.id, 20, got, n);
    if (got) expect_rsp(s);
    @(posedge clk); #1;
    drive_req(s, 1'b0);
    drain(30);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    chk({tag, "_rsp_id"}, rsp_id, 1'b0);
    chk({tag, "_rsp_result"}, rsp_result, 16'h0000);
    chk({tag, "_rsp_zero"}, rsp_zero, 1'b0);
    chk({tag, "_rsp_err"}, rsp_err, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_fpu"}, {fpu_a, fpu_b, fpu_aluctrl}, 36'h0);
    chk({tag, "_ready"}, {req0_ready, req1_ready}, 2'b00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  vec_t tbl[6];

  initial begin
    tbl[0] = mk(1'b0, 16'h3C00, 16'h4000, OP_FADD, 16'h4200, 1'b0, 1'b0);
    tbl[1] = mk(1'b1, 16'h3C00, 16'hBC00, OP_FADD, 16'h0000, 1'b1, 1'b0);
    tbl[2] = mk(1'b1, 16'h4000, 16'h4200, OP_FMUL, 16'h4600, 1'b0, 1'b0);
`ifdef FPU_ARB_OPCHECK_EN
    tbl[3] = mk(1'b1, 16'h5555, 16'h0AAA, OP_BAD, 16'h0000, 1'b1, 1'b1);
`else
    tbl[3] = mk(1'b1, 16'h5555, 16'h0AAA, OP_BAD, 16'h5FF0, 1'b0, 1'b0);
`endif
    tbl[4] = mk(1'b1, 16'h1234, 16'h00FF, OP_FMUL, 16'h12CA, 1'b0, 1'b0);
    tbl[5] = mk(1'b0, 16'h8000, 16'h0000, OP_FADD, 16'h8000, 1'b1, 1'b0);

    repeat (2) @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1 rst = 1'b0;
    rsp_ready = 1'b1;

    // Simultaneous requests straight out of reset: requester 0 first.
    both(mk(1'b0, 16'h4000, 16'h4200, OP_FMUL, 16'h4600, 1'b0, 1'b0),
         mk(1'b1, 16'h3E00, 16'h3E00, OP_FADD, 16'h4200, 1'b0, 1'b0), 1'b0, "both_rst");

    for (int unsigned i = 0; i < 6; i++) begin
      issue(tbl[i]);
      drain(30);
    end

    // Last table entry was requester 0, so a tie now goes to requester 1.
    both(mk(1'b0, 16'h3C00, 16'h4000, OP_FADD, 16'h4200, 1'b0, 1'b0),
         mk(1'b1, 16'h4000, 16'h4200, OP_FMUL, 16'h4600, 1'b0, 1'b0), 1'b1, "both_rr");

    // Consumer stalls in DONE while requester 1 waits.
    begin
      int n;
      rsp_ready = 1'b0;
      issue(tbl[0]);
      @(posedge clk); #1;
      drive_req(mk(1'b1, 16'h4000, 16'h4200, OP_FMUL, 16'h4600, 1'b0, 1'b0), 1'b1);
      n = 0;
      while (rsp_valid !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("stall_reach_done", rsp_valid, 1'b1);
      repeat (5) begin
        @(negedge clk);
        chk("stall_valid", rsp_valid, 1'b1);
        chk("stall_result", rsp_result, 16'h4200);
        chk("stall_r1_ready", req1_ready, 1'b0);
        chk("stall_busy", busy, 1'b1);
      end
      @(posedge clk); #1 rsp_ready = 1'b1;
      @(negedge clk);
      chk("stall_hs_r1_ready", req1_ready, 1'b0);
      @(negedge clk);
      chk("regrant_r1", req1_ready, 1'b1);
      if (req1_ready) expect_rsp(mk(1'b1, 16'h4000, 16'h4200, OP_FMUL, 16'h4600, 1'b0, 1'b0));
      @(posedge clk); #1 req1_valid = 1'b0;
      drain(30);
    end

    // A request raised and withdrawn while busy must leave no trace.
    issue(mk(1'b0, 16'h3C00, 16'hBC00, OP_FADD, 16'h0000, 1'b1, 1'b0));
    @(posedge clk); #1;
    drive_req(mk(1'b1, 16'h1111, 16'h2222, OP_FADD, 16'h0000, 1'b0, 1'b0), 1'b1);
    @(negedge clk);
    chk("drop_r1_ready", req1_ready, 1'b0);
    @(posedge clk); #1 req1_valid = 1'b0;
    drain(30);
    repeat (3) begin
      @(negedge clk);
      chk("drop_idle", busy, 1'b0);
    end

    // Reset in the first EXEC cycle aborts; pointer (left at 1) returns to 0.
    issue(mk(1'b0, 16'h4000, 16'h4200, OP_FMUL, 16'h4600, 1'b0, 1'b0));
    #2 rst = 1'b1;
    #1 check_zero("rst_mid");
    sb.delete();
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("rst_no_rsp", rsp_valid, 1'b0);
      chk("rst_idle", busy, 1'b0);
    end
    both(mk(1'b0, 16'h3C00, 16'h4000, OP_FADD, 16'h4200, 1'b0, 1'b0),
         mk(1'b1, 16'h3E00, 16'h3E00, OP_FADD, 16'h4200, 1'b0, 1'b0), 1'b0, "both_ptr_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
